// File: rtl/ps2_joypad_decoder_pkg.sv
// ============================================================================
// ps2_joypad_decoder_pkg : NES joypad button indices, PS/2 scan codes, rx FSM
// Revision 1.0
// ============================================================================
`default_nettype none

package ps2_joypad_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_A      = 8'h22;
  localparam logic [7:0] SC_B      = 8'h1A;
  localparam logic [7:0] SC_SELECT = 8'h59;
  localparam logic [7:0] SC_START  = 8'h5A;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Arrow codes without E0 come from the keypad and must map to nothing.
  function automatic logic [7:0] button_mask(input logic [7:0] code, input logic ext);
    logic [7:0] mask;
    mask = 8'h00;
    case (code)
      SC_A:      if (!ext) mask[BTN_A] = 1'b1;
      SC_B:      if (!ext) mask[BTN_B] = 1'b1;
      SC_SELECT: if (!ext) mask[BTN_SELECT] = 1'b1;
      SC_START:  mask[BTN_START] = 1'b1;
      SC_UP:     if (ext) mask[BTN_UP] = 1'b1;
      SC_DOWN:   if (ext) mask[BTN_DOWN] = 1'b1;
      SC_LEFT:   if (ext) mask[BTN_LEFT] = 1'b1;
      SC_RIGHT:  if (ext) mask[BTN_RIGHT] = 1'b1;
      default:   mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_joypad_decoder_ps2_rx.sv
// ============================================================================
// ps2_rx : synchronised PS/2 frame receiver with parity check and timeout
// Revision 1.0
// ============================================================================
`default_nettype none

module ps2_rx
  import ps2_joypad_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_done,
  output logic [7:0] byte_data,
  output logic       scan_valid,
  output logic [7:0] scan_byte,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  rx_state_t     state;
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          parity_ok;
  logic [TW-1:0] tcnt;
  logic          fall;
  logic          bit_in;

  assign fall      = clk_prev & ~clk_sync[1];
  assign bit_in    = data_sync[1];
  assign byte_done = fall && (state == ST_STOP) && bit_in && parity_ok;
  assign byte_data = shift_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      clk_sync   <= 2'b00;
      data_sync  <= 2'b00;
      clk_prev   <= 1'b0;
      shift_reg  <= 8'h00;
      bit_cnt    <= 3'd0;
      parity_ok  <= 1'b0;
      tcnt       <= '0;
      scan_valid <= 1'b0;
      scan_byte  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_prev   <= clk_sync[1];
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;

      if ((state != ST_IDLE) && !fall) begin
        if (tcnt == T_LAST) begin
          state     <= ST_IDLE;
          shift_reg <= 8'h00;
          bit_cnt   <= 3'd0;
          tcnt      <= '0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end

      if (fall) begin
        case (state)
          ST_IDLE: begin
            bit_cnt <= 3'd0;
            if (!bit_in) state <= ST_DATA;
            else         frame_err <= 1'b1;
          end
          ST_DATA: begin
            shift_reg <= {bit_in, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_ok <= ^{bit_in, shift_reg};
            state     <= ST_STOP;
          end
          ST_STOP: begin
            if (bit_in && parity_ok) begin
              scan_valid <= 1'b1;
              scan_byte  <= shift_reg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_joypad_decoder.sv
// ============================================================================
// ps2_joypad_decoder : PS/2 keyboard to NES joypad button mask
// Revision 1.0
// ============================================================================
`default_nettype none

module ps2_joypad_decoder
  import ps2_joypad_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycodes,
  output logic       scan_valid,
  output logic [7:0] scan_byte,
  output logic       frame_err
);

  logic       byte_done;
  logic [7:0] byte_data;
  logic       ext_flag;
  logic       brk_flag;
  logic [7:0] mask;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_done (byte_done),
    .byte_data (byte_data),
    .scan_valid(scan_valid),
    .scan_byte (scan_byte),
    .frame_err (frame_err)
  );

  assign mask = button_mask(byte_data, ext_flag);

  // Decoding on byte_done lands keycodes on the same edge that raises scan_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keycodes <= 8'h00;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_done) begin
      if (byte_data == SC_EXT) begin
        ext_flag <= 1'b1;
      end else if (byte_data == SC_BRK) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        keycodes <= brk_flag ? (keycodes & ~mask) : (keycodes | mask);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_joypad_decoder.sv
// ============================================================================
// tb_ps2_joypad_decoder : scoreboard bench for the PS/2 joypad decoder
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ps2_joypad_decoder;

  localparam int TO   = 200;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycodes;
  logic       scan_valid;
  logic [7:0] scan_byte;
  logic       frame_err;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    logic [7:0] k;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [7:0] m_keys = 8'h00;

  ps2_joypad_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycodes  (keycodes),
    .scan_valid(scan_valid),
    .scan_byte (scan_byte),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic push_good(input logic [7:0] b);
    logic [7:0] m;
    exp_t e;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      case (b)
        8'h22:   m = m_ext ? 8'h00 : 8'h01;
        8'h1A:   m = m_ext ? 8'h00 : 8'h02;
        8'h59:   m = m_ext ? 8'h00 : 8'h04;
        8'h5A:   m = 8'h08;
        8'h75:   m = m_ext ? 8'h10 : 8'h00;
        8'h72:   m = m_ext ? 8'h20 : 8'h00;
        8'h6B:   m = m_ext ? 8'h40 : 8'h00;
        8'h74:   m = m_ext ? 8'h80 : 8'h00;
        default: m = 8'h00;
      endcase
      m_keys = m_brk ? (m_keys & ~m) : (m_keys | m);
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end
    e.is_err = 1'b0; e.b = b; e.k = m_keys;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.b = 8'h00; e.k = m_keys;
    q.push_back(e);
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_par || bad_stop) push_err();
    else                     push_good(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check_eq("queue_empty", 8'(q.size()), 8'h00);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && (scan_valid === 1'b1 || frame_err === 1'b1)) begin
      if (q.size() == 0) begin
        check_eq("unexpected_output", {6'b0, scan_valid, frame_err}, 8'h00);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_eq("kind_is_err", {7'b0, frame_err}, {7'b0, e.is_err});
        if (!e.is_err) check_eq("scan_byte", scan_byte, e.b);
        check_eq("keycodes", keycodes, e.k);
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_keycodes", keycodes, 8'h00);
    check_eq("rst_scan_byte", scan_byte, 8'h00);
    check_eq("rst_scan_valid", {7'b0, scan_valid}, 8'h00);
    check_eq("rst_frame_err", {7'b0, frame_err}, 8'h00);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    send_frame(8'h22, 0, 0);                       // A make -> 01
    send_frame(8'hF0, 0, 0); send_frame(8'h22, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'h1A, 1, 0);                       // bad parity
    drain();
    check_eq("keys_after_parity_err", keycodes, m_keys);
    send_frame(8'h75, 0, 0);                       // keypad 8: no change
    send_frame(8'h1C, 0, 0);                       // unmapped
    send_frame(8'h22, 0, 1);                       // bad stop
    push_err(); ps2_bit(1'b1); ps2_data = 1'b1;    // bad start
    repeat (20) @(posedge clk);
    drain();
    check_eq("keys_after_errs", keycodes, 8'h00);

    push_err();                                    // timeout after 4 data bits
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    ps2_data = 1'b1;
    repeat (TO + 20) @(posedge clk);
    send_frame(8'h5A, 0, 0);
    send_frame(8'h1A, 0, 0); send_frame(8'h1A, 0, 0);
    send_frame(8'h59, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h72, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h74, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h5A, 0, 0);
    drain();
    check_eq("keys_all_dirs", keycodes, 8'hF6);

    send_frame(8'h22, 0, 0);                       // reach 0x81
    for (int i = 0; i < 4; i++) begin
      logic [7:0] rel;
      rel = 8'h59 >> 0;
      case (i)
        0: rel = 8'h1A;
        1: rel = 8'h59;
        default: rel = 8'h00;
      endcase
      if (i < 2) begin
        send_frame(8'hF0, 0, 0); send_frame(rel, 0, 0);
      end else begin
        send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0);
        send_frame((i == 2) ? 8'h72 : 8'h75, 0, 0);
      end
    end
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h6B, 0, 0);
    drain();
    check_eq("keys_before_reset", keycodes, 8'h81);

    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);   // partial frame, then reset
    reset_n = 1'b0;
    #1;
    check_eq("midreset_keycodes", keycodes, 8'h00);
    check_eq("midreset_state", 8'(dut.u_rx.state), 8'h00);
    m_keys = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h22, 0, 0);
    drain();
    check_eq("keys_after_reset", keycodes, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
